// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: fetch FSM states, the reset PC and the NOP encoding.
package pipe_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_e;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam logic [31:0] NOP      = 32'h0000_0000;

  function automatic logic [31:0] word_addr(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// Generic pipeline register: valid, instruction, pc and pc+4 with flush > stall > load priority.
module if_id_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              stall,
  input  logic              load,
  input  logic [DATA_W-1:0] instr,
  input  logic [DATA_W-1:0] pc,
  input  logic [DATA_W-1:0] pc4,
  output logic              valid_q,
  output logic [DATA_W-1:0] instr_q,
  output logic [DATA_W-1:0] pc_q,
  output logic [DATA_W-1:0] pc4_q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      instr_q <= DATA_W'(NOP);
      pc_q    <= '0;
      pc4_q   <= DATA_W'(4);
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (!stall) begin
      // An unstalled cycle without a load leaves a bubble behind.
      valid_q <= load;
      if (load) begin
        instr_q <= instr;
        pc_q    <= pc;
        pc4_q   <= pc4;
      end
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, single-outstanding imem request FSM, skid buffer
// for responses that arrive during a stall, and the IF/ID pipeline register.
module if_stage #(
  parameter logic [31:0] RESET_PC = pipe_pkg::RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] npc_i,
  input  logic        redirect_i,
  input  logic        stall_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        if_id_valid_o,
  output logic [31:0] if_id_instr_o,
  output logic [31:0] if_id_pc_o,
  output logic [31:0] if_id_pc4_o
);
  import pipe_pkg::*;

  fetch_state_e state, state_n;
  logic [31:0]  pc, pc_n, pc_plus4;
  logic [31:0]  skid_instr, skid_pc;
  logic [31:0]  drain_addr;
  logic         skid_load, drain_load, ifid_load, use_skid;
  logic [31:0]  ld_instr, ld_pc, ld_pc4;

  assign pc_plus4 = pc + 32'd4;

  always_comb begin
    state_n    = state;
    pc_n       = pc;
    skid_load  = 1'b0;
    drain_load = 1'b0;
    ifid_load  = 1'b0;
    use_skid   = 1'b0;
    case (state)
      IDLE: state_n = FETCH;
      FETCH: begin
        if (redirect_i) begin
          pc_n = npc_i;
          if (!imem_rvalid_i) begin
            // Outstanding request must still complete at its original address.
            state_n    = DRAIN;
            drain_load = 1'b1;
          end
        end else if (imem_rvalid_i) begin
          pc_n = pc_plus4;
          if (stall_i) begin
            skid_load = 1'b1;
            state_n   = HOLD;
          end else begin
            ifid_load = 1'b1;
          end
        end
      end
      HOLD: begin
        if (redirect_i) begin
          pc_n    = npc_i;
          state_n = FETCH;
        end else if (!stall_i) begin
          ifid_load = 1'b1;
          use_skid  = 1'b1;
          state_n   = FETCH;
        end
      end
      DRAIN: begin
        if (redirect_i) pc_n = npc_i;
        if (imem_rvalid_i) state_n = FETCH;
      end
      default: state_n = IDLE;
    endcase
  end

  // ---- state / PC registers ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pc    <= RESET_PC;
    end else begin
      state <= state_n;
      pc    <= pc_n;
    end
  end

  // ---- skid and abandoned-address data registers ----
  always_ff @(posedge clk) begin
    if (skid_load) begin
      skid_instr <= imem_rdata_i;
      skid_pc    <= pc;
    end
    if (drain_load) drain_addr <= word_addr(pc);
  end

  assign imem_req_o  = (state == FETCH) || (state == DRAIN);
  assign imem_addr_o = (state == DRAIN) ? drain_addr : word_addr(pc);

  assign ld_instr = use_skid ? skid_instr : imem_rdata_i;
  assign ld_pc    = use_skid ? skid_pc    : pc;
  assign ld_pc4   = ld_pc + 32'd4;

  // ---- IF/ID boundary ----
  if_id_reg #(
    .DATA_W(32)
  ) u_if_id (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (redirect_i),
    .stall   (stall_i),
    .load    (ifid_load),
    .instr   (ld_instr),
    .pc      (ld_pc),
    .pc4     (ld_pc4),
    .valid_q (if_id_valid_o),
    .instr_q (if_id_instr_o),
    .pc_q    (if_id_pc_o),
    .pc4_q   (if_id_pc4_o)
  );

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios plus a randomized run checked against an
// instruction-stream model (sequential PCs, redirects restart the stream, stalls freeze IF/ID).
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] npc_i = '0;
  logic        redirect_i = 1'b0;
  logic        stall_i = 1'b0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = '0;
  logic        if_id_valid_o;
  logic [31:0] if_id_instr_o;
  logic [31:0] if_id_pc_o;
  logic [31:0] if_id_pc4_o;

  int total = 0;
  int bad = 0;

  // memory model state
  int          lat_mode = 0;
  bit          mem_busy = 1'b0;
  int          mem_wait = 0;
  logic [31:0] mem_addr = '0;
  int          proto_err = 0;

  if_stage dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .npc_i         (npc_i),
    .redirect_i    (redirect_i),
    .stall_i       (stall_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .if_id_valid_o (if_id_valid_o),
    .if_id_instr_o (if_id_instr_o),
    .if_id_pc_o    (if_id_pc_o),
    .if_id_pc4_o   (if_id_pc4_o)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[31:2], 2'b00} ^ 32'h5A5A_C3C3;
  endfunction

  // One clock cycle: drive inputs, answer the memory, take the edge, settle 1 time unit.
  task automatic drive(input bit st, input bit rd, input logic [31:0] np);
    stall_i    = st;
    redirect_i = rd;
    npc_i      = np;
    if (imem_req_o) begin
      if (!mem_busy) begin
        mem_busy = 1'b1;
        mem_wait = (lat_mode < 0) ? int'($urandom_range(0, 3)) : lat_mode;
        mem_addr = imem_addr_o;
      end else if (imem_addr_o !== mem_addr) begin
        proto_err++;
      end
      imem_rvalid_i = (mem_wait == 0);
    end else begin
      if (mem_busy) proto_err++;
      imem_rvalid_i = 1'b0;
    end
    imem_rdata_i = imem_rvalid_i ? mem_word(imem_addr_o) : 32'($urandom);
    @(posedge clk);
    if (imem_rvalid_i) mem_busy = 1'b0;
    else if (mem_busy) mem_wait--;
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; stall_i = 1'b0; redirect_i = 1'b0; npc_i = '0;
    imem_rvalid_i = 1'b0; imem_rdata_i = '0;
    mem_busy = 1'b0; proto_err = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [31:0] a;
    do_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    total++; if (imem_req_o !== 1'b0) begin bad++; $display("FAIL rst_req: got %b want 0", imem_req_o); end
    total++; if (imem_addr_o !== 32'h3000) begin bad++; $display("FAIL rst_addr: got %h want 00003000", imem_addr_o); end
    total++; if ({if_id_valid_o, if_id_instr_o, if_id_pc_o, if_id_pc4_o} !== {1'b0, 32'h0, 32'h0, 32'h4})
      begin bad++; $display("FAIL rst_ifid: got v=%b i=%h pc=%h pc4=%h want 0/0/0/4", if_id_valid_o, if_id_instr_o, if_id_pc_o, if_id_pc4_o); end
    rst_n = 1'b1;
    lat_mode = 0;
    drive(1'b0, 1'b0, 32'h0);
    for (int k = 0; k < 3; k++) begin
      a = 32'h3000 + 32'(4 * k);
      total++; if ({imem_req_o, imem_addr_o} !== {1'b1, a})
        begin bad++; $display("FAIL seq_addr%0d: got req=%b addr=%h want 1/%h", k, imem_req_o, imem_addr_o, a); end
      drive(1'b0, 1'b0, 32'h0);
      total++; if ({if_id_valid_o, if_id_pc_o, if_id_pc4_o, if_id_instr_o} !== {1'b1, a, a + 32'd4, mem_word(a)})
        begin bad++; $display("FAIL seq_ifid%0d: got v=%b pc=%h pc4=%h i=%h want pc %h", k, if_id_valid_o, if_id_pc_o, if_id_pc4_o, if_id_instr_o, a); end
    end
  endtask

  task automatic test_latency();
    logic [31:0] a;
    do_reset();
    lat_mode = 2;
    drive(1'b0, 1'b0, 32'h0);
    for (int k = 0; k < 3; k++) begin
      a = 32'h3000 + 32'(4 * k);
      for (int c = 0; c < 3; c++) begin
        total++; if ({imem_req_o, imem_addr_o} !== {1'b1, a})
          begin bad++; $display("FAIL lat_hold%0d_%0d: got req=%b addr=%h want 1/%h", k, c, imem_req_o, imem_addr_o, a); end
        drive(1'b0, 1'b0, 32'h0);
        if (c < 2) begin
          total++; if (if_id_valid_o !== 1'b0)
            begin bad++; $display("FAIL lat_bubble%0d_%0d: got valid=%b want 0", k, c, if_id_valid_o); end
        end else begin
          total++; if ({if_id_valid_o, if_id_pc_o, if_id_instr_o} !== {1'b1, a, mem_word(a)})
            begin bad++; $display("FAIL lat_load%0d: got v=%b pc=%h i=%h want pc %h", k, if_id_valid_o, if_id_pc_o, if_id_instr_o, a); end
        end
      end
    end
    total++; if (proto_err !== 0) begin bad++; $display("FAIL lat_proto: got %0d violations want 0", proto_err); end
  endtask

  task automatic test_stall();
    do_reset();
    lat_mode = 0;
    drive(1'b0, 1'b0, 32'h0);
    drive(1'b0, 1'b0, 32'h0);
    for (int c = 0; c < 2; c++) begin
      drive(1'b1, 1'b0, 32'h0);
      total++; if ({if_id_valid_o, if_id_pc_o, if_id_instr_o, imem_req_o} !== {1'b1, 32'h3000, mem_word(32'h3000), 1'b0})
        begin bad++; $display("FAIL stall_hold%0d: got v=%b pc=%h i=%h req=%b want 1/3000/-/0", c, if_id_valid_o, if_id_pc_o, if_id_instr_o, imem_req_o); end
    end
    drive(1'b0, 1'b0, 32'h0);
    total++; if ({if_id_valid_o, if_id_pc_o, if_id_pc4_o, if_id_instr_o} !== {1'b1, 32'h3004, 32'h3008, mem_word(32'h3004)})
      begin bad++; $display("FAIL stall_skid: got v=%b pc=%h pc4=%h i=%h want pc 3004", if_id_valid_o, if_id_pc_o, if_id_pc4_o, if_id_instr_o); end
    total++; if ({imem_req_o, imem_addr_o} !== {1'b1, 32'h3008})
      begin bad++; $display("FAIL stall_next: got req=%b addr=%h want 1/00003008", imem_req_o, imem_addr_o); end
    drive(1'b0, 1'b0, 32'h0);
    total++; if ({if_id_valid_o, if_id_pc_o} !== {1'b1, 32'h3008})
      begin bad++; $display("FAIL stall_after: got v=%b pc=%h want 1/00003008", if_id_valid_o, if_id_pc_o); end
  endtask

  task automatic test_redirect_drain();
    do_reset();
    lat_mode = 1;
    drive(1'b0, 1'b0, 32'h0);
    repeat (4) drive(1'b0, 1'b0, 32'h0);
    total++; if ({imem_req_o, imem_addr_o} !== {1'b1, 32'h3008})
      begin bad++; $display("FAIL drn_pre: got req=%b addr=%h want 1/00003008", imem_req_o, imem_addr_o); end
    drive(1'b0, 1'b1, 32'h3100);
    total++; if ({imem_req_o, imem_addr_o, if_id_valid_o} !== {1'b1, 32'h3008, 1'b0})
      begin bad++; $display("FAIL drn_hold: got req=%b addr=%h v=%b want 1/00003008/0", imem_req_o, imem_addr_o, if_id_valid_o); end
    drive(1'b0, 1'b0, 32'h0);
    total++; if ({imem_req_o, imem_addr_o, if_id_valid_o} !== {1'b1, 32'h3100, 1'b0})
      begin bad++; $display("FAIL drn_done: got req=%b addr=%h v=%b want 1/00003100/0", imem_req_o, imem_addr_o, if_id_valid_o); end
    drive(1'b0, 1'b0, 32'h0);
    total++; if (if_id_valid_o !== 1'b0) begin bad++; $display("FAIL drn_gap: got v=%b want 0", if_id_valid_o); end
    drive(1'b0, 1'b0, 32'h0);
    total++; if ({if_id_valid_o, if_id_pc_o, if_id_instr_o} !== {1'b1, 32'h3100, mem_word(32'h3100)})
      begin bad++; $display("FAIL drn_target: got v=%b pc=%h i=%h want pc 00003100", if_id_valid_o, if_id_pc_o, if_id_instr_o); end
    total++; if (proto_err !== 0) begin bad++; $display("FAIL drn_proto: got %0d violations want 0", proto_err); end
  endtask

  task automatic test_redirect_hold();
    do_reset();
    lat_mode = 0;
    drive(1'b0, 1'b0, 32'h0);
    drive(1'b0, 1'b0, 32'h0);
    drive(1'b1, 1'b0, 32'h0);
    drive(1'b1, 1'b1, 32'h3200);
    total++; if ({if_id_valid_o, imem_req_o, imem_addr_o} !== {1'b0, 1'b1, 32'h3200})
      begin bad++; $display("FAIL hold_redir: got v=%b req=%b addr=%h want 0/1/00003200", if_id_valid_o, imem_req_o, imem_addr_o); end
    drive(1'b0, 1'b0, 32'h0);
    total++; if ({if_id_valid_o, if_id_pc_o, if_id_pc4_o} !== {1'b1, 32'h3200, 32'h3204})
      begin bad++; $display("FAIL hold_target: got v=%b pc=%h pc4=%h want 1/00003200/00003204", if_id_valid_o, if_id_pc_o, if_id_pc4_o); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    lat_mode = 0;
    drive(1'b0, 1'b0, 32'h0);
    drive(1'b0, 1'b0, 32'h0);
    drive(1'b0, 1'b0, 32'h0);
    lat_mode = 3;
    drive(1'b0, 1'b0, 32'h0);
    total++; if ({imem_req_o, imem_addr_o} !== {1'b1, 32'h3008})
      begin bad++; $display("FAIL mid_pending: got req=%b addr=%h want 1/00003008", imem_req_o, imem_addr_o); end
    rst_n = 1'b0;
    #1;
    total++; if ({imem_req_o, imem_addr_o, if_id_valid_o} !== {1'b0, 32'h3000, 1'b0})
      begin bad++; $display("FAIL mid_abort: got req=%b addr=%h v=%b want 0/00003000/0", imem_req_o, imem_addr_o, if_id_valid_o); end
    mem_busy = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    lat_mode = 0;
    drive(1'b0, 1'b0, 32'h0);
    total++; if ({imem_req_o, imem_addr_o} !== {1'b1, 32'h3000})
      begin bad++; $display("FAIL mid_restart: got req=%b addr=%h want 1/00003000", imem_req_o, imem_addr_o); end
    drive(1'b0, 1'b0, 32'h0);
    total++; if ({if_id_valid_o, if_id_pc_o} !== {1'b1, 32'h3000})
      begin bad++; $display("FAIL mid_first: got v=%b pc=%h want 1/00003000", if_id_valid_o, if_id_pc_o); end
  endtask

  task automatic test_random();
    logic [31:0] exp_pc, np;
    logic [31:0] s_i, s_pc, s_pc4;
    logic        s_v;
    bit          st, rd;
    int          delivered, r;
    do_reset();
    lat_mode = -1;
    exp_pc = 32'h3000;
    delivered = 0;
    drive(1'b0, 1'b0, 32'h0);
    for (int n = 0; n < 2000; n++) begin
      st = ($urandom_range(0, 3) == 0);
      rd = ($urandom_range(0, 9) == 0);
      r  = int'($urandom_range(0, 9));
      if (r == 0) np = 32'hFFFF_FFF4;
      else if (r == 1) np = 32'($urandom);
      else np = 32'h0000_4000 + (32'($urandom_range(0, 255)) << 2);
      s_v = if_id_valid_o; s_i = if_id_instr_o; s_pc = if_id_pc_o; s_pc4 = if_id_pc4_o;
      drive(st, rd, np);
      if (rd) begin
        exp_pc = np;
        total++; if (if_id_valid_o !== 1'b0)
          begin bad++; $display("FAIL rnd_flush@%0d: got v=%b want 0", n, if_id_valid_o); end
      end else if (st) begin
        total++; if ({if_id_valid_o, if_id_instr_o, if_id_pc_o, if_id_pc4_o} !== {s_v, s_i, s_pc, s_pc4})
          begin bad++; $display("FAIL rnd_stall@%0d: got pc=%h v=%b want unchanged pc=%h v=%b", n, if_id_pc_o, if_id_valid_o, s_pc, s_v); end
      end else if (if_id_valid_o === 1'b1) begin
        total++;
        if ({if_id_pc_o, if_id_pc4_o, if_id_instr_o} !== {exp_pc, exp_pc + 32'd4, mem_word(exp_pc)}) begin
          bad++;
          $display("FAIL rnd_stream@%0d: got pc=%h pc4=%h i=%h want pc=%h i=%h", n, if_id_pc_o, if_id_pc4_o, if_id_instr_o, exp_pc, mem_word(exp_pc));
        end
        exp_pc = exp_pc + 32'd4;
        delivered++;
      end
    end
    total++; if (delivered < 50) begin bad++; $display("FAIL rnd_progress: got %0d deliveries want >=50", delivered); end
    total++; if (proto_err !== 0) begin bad++; $display("FAIL rnd_proto: got %0d violations want 0", proto_err); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_stall();
    test_redirect_drain();
    test_redirect_hold();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
